// File: rtl/tick_divider_ctl.sv
// Parametrised tick divider: one-cycle tick plus near-50% divided square wave,
// double-buffered divisor applied at period boundaries, continuous/one-shot modes.
module tick_divider_ctl #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned RESET_DIV = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] divider,
  input  logic             div_load,
  input  logic             oneshot,
  input  logic             start,
  output logic             tick,
  output logic             clk_out,
  output logic             busy,
  output logic             load_pending,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] RESET_DIV_W = WIDTH'(RESET_DIV);
  localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] div_s_q, div_s_d;
  logic             pend_q, pend_d;
  logic             tick_q, tick_d;
  logic             clk_out_q, clk_out_d;

  logic             term;
  logic             adv;
  logic             apply;

  // State, counter, divisor and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_q     <= RESET_DIV_W;
      div_s_q   <= '0;
      pend_q    <= 1'b0;
      tick_q    <= 1'b0;
      clk_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      div_s_q   <= div_s_d;
      pend_q    <= pend_d;
      tick_q    <= tick_d;
      clk_out_q <= clk_out_d;
    end
  end

  // Next-state logic: FSM, counter, divisor buffering and square-wave phase.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    div_s_d   = div_s_q;
    pend_d    = pend_q;
    tick_d    = 1'b0;
    clk_out_d = clk_out_q;

    term  = (cnt_q == div_q);
    adv   = (state_q == RUN) && en;
    apply = (state_q == IDLE) || (adv && term);

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!oneshot || start) state_d = RUN;
      end
      RUN: begin
        if (en) begin
          tick_d = term;
          cnt_d  = term ? '0 : cnt_q + ONE;
          if (term && oneshot) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (div_load) begin
      div_s_d = divider;
      if (apply) begin
        div_d  = divider;
        pend_d = 1'b0;
      end else begin
        pend_d = 1'b1;
      end
    end else if (apply && pend_q) begin
      div_d  = div_s_q;
      pend_d = 1'b0;
    end

    // Phase is judged against the divisor in force next cycle so a freshly
    // applied divisor shapes the very first period after the boundary.
    if ((state_q == IDLE) || en) begin
      clk_out_d = (state_d == RUN) && (div_d != '0) && (cnt_d <= (div_d >> 1));
    end
  end

  assign tick         = tick_q;
  assign clk_out      = clk_out_q;
  assign busy         = (state_q == RUN);
  assign load_pending = pend_q;
  assign count        = cnt_q;

endmodule

// File: doc/tick_divider_ctl.md
Name: tick_divider_ctl

Overview:
Parametrised successor to the 8-bit free-running tick divider. It derives a one-cycle tick and a near-50% divided square wave from the system clock. Width is generic and the divisor is double-buffered, taking effect at a glitch-free period boundary. It supports continuous and one-shot modes and a clock-enable. Used by protocol timing engines (bit-cell strobes, timeouts) that need a retunable strobe without a restart glitch.

Parameters:
WIDTH, 16, counter/divisor width in bits (>=2)
RESET_DIV, 0, divisor loaded into the active register at reset (must fit in WIDTH)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
en  input  1  clock-enable; counter advances only when high
divider  input  WIDTH  requested period minus one (period = divider+1 enabled cycles)
div_load  input  1  one-cycle strobe; captures divider into shadow register
oneshot  input  1  0 = continuous mode, 1 = one-shot mode
start  input  1  one-cycle strobe; arms one period in one-shot mode
tick  output  1  registered one-cycle pulse after terminal count
clk_out  output  1  registered divided square wave
busy  output  1  high while a period is being counted (state RUN)
load_pending  output  1  shadow divisor captured, not yet applied
count  output  WIDTH  current counter value (cnt_q)

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: cnt_q=0, div_q=RESET_DIV, div_s=0, load_pending=0, tick=0, clk_out=0, state=IDLE, busy=0. Reset mid-period aborts with no tick; a pending load is discarded.
- States: IDLE, RUN. busy = (state==RUN).
- IDLE->RUN: oneshot=0 (continuous, entered the next cycle regardless of en), or oneshot=1 and start=1. In IDLE cnt_q holds at 0 and tick=0.
- RUN, en=1: terminal count is cnt_q==div_q. At terminal count cnt_q<=0, else cnt_q<=cnt_q+1. WIDTH-bit arithmetic; cnt_q never exceeds div_q.
- RUN, en=0: cnt_q, clk_out and state hold; tick=0.
- tick: tick<=1 in the cycle after an enabled terminal count, otherwise 0. Latency is 1 cycle. div_q=0 with en held gives a tick every cycle.
- At an enabled terminal count with oneshot=1: RUN->IDLE (one-shot completes; also finishes a continuous period if oneshot rose mid-period). With oneshot=0: stay in RUN.
- start while busy: ignored. start with oneshot=0: ignored.
- clk_out: registered. In RUN with en=1, clk_out<=1 when next cnt <= (div_q>>1), else 0. Forced to 0 in IDLE and when div_q==0.
  - div_q=3 gives 2 high / 2 low.
  - div_q=4 gives 3 high / 2 low.
- Divisor double-buffering:
  - div_load captures divider into div_s and sets load_pending.
  - At the next enabled terminal count, or in any IDLE cycle, div_q<=div_s and load_pending clears.
  - div_load coincident with a terminal count (or IDLE): divider goes directly into div_q, and load_pending stays 0.
  - A second div_load before apply overwrites div_s; the last value wins.
- count output is cnt_q directly.

Test Plan:
1. Reset with RESET_DIV=0, oneshot=0, en=1 -> tick=1 every cycle from cycle 2 after reset release; clk_out=0; count=0.
2. div_load with divider=4 during continuous running at div_q=0 -> applied on the next tick; then tick period 5 cycles, clk_out pattern 1,1,1,0,0; load_pending=0 throughout.
3. Continuous running at div_q=9, count=3; div_load divider=2 -> load_pending=1; count runs to 9 unchanged; one tick; then period 3 and load_pending=0.
4. oneshot=1, div_q=5, start pulse -> busy=1 for 6 enabled cycles, exactly one tick, then busy=0 and count=0; a start asserted while busy produces no second tick.
5. div_q=7, en toggled 1,0,0,1 mid-period -> count freezes while en=0; tick arrives 2 cycles late; clk_out holds while frozen.
6. rst asserted at count=5 with load pending -> next cycle count=0, tick=0, clk_out=0, load_pending=0, div_q=RESET_DIV.
